// File: rtl/agex_br_resolve_pkg.sv
// Shared definitions for the AGEX branch resolution unit: funct3 codes, FSM encodings and bus width.
package agex_br_resolve_pkg;

    localparam int BR_DBITS        = 32;
    localparam int BR_PHT_IDX_BITS = 8;

    localparam logic [2:0] BR_F3_BEQ  = 3'b000;
    localparam logic [2:0] BR_F3_BNE  = 3'b001;
    localparam logic [2:0] BR_F3_BLT  = 3'b100;
    localparam logic [2:0] BR_F3_BGE  = 3'b101;
    localparam logic [2:0] BR_F3_BLTU = 3'b110;
    localparam logic [2:0] BR_F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } br_state_t;

    function automatic int bus_width(input int dbits, input int pht_bits);
        return 3 + 3 * dbits + pht_bits;
    endfunction

    localparam int FROM_AGEX_TO_FE_WIDTH = bus_width(BR_DBITS, BR_PHT_IDX_BITS);

endpackage

// File: rtl/agex_br_resolve_br_cond_eval.sv
// Combinational branch condition evaluator: (funct3, rs1, rs2) -> cmp.
module agex_br_resolve_br_cond_eval
    import agex_br_resolve_pkg::*;
#(
    parameter int DBITS = BR_DBITS
) (
    input  logic [2:0]       funct3,
    input  logic [DBITS-1:0] rs1,
    input  logic [DBITS-1:0] rs2,
    output logic             cmp
);

    always_comb begin
        cmp = 1'b0;
        case (funct3)
            BR_F3_BEQ:  cmp = (rs1 == rs2);
            BR_F3_BNE:  cmp = (rs1 != rs2);
            BR_F3_BLT:  cmp = ($signed(rs1) < $signed(rs2));
            BR_F3_BGE:  cmp = ($signed(rs1) >= $signed(rs2));
            BR_F3_BLTU: cmp = (rs1 < rs2);
            BR_F3_BGEU: cmp = (rs1 >= rs2);
            // 010/011 are not branch encodings and never compare true
            default:    cmp = 1'b0;
        endcase
    end

endmodule

// File: rtl/agex_br_resolve.sv
// AGEX branch resolution: computes taken/target, detects mispredicts, drives FE redirect/training bus
// and squashes wrong-path instructions. Optional perf counters under `BR_PERF_CNT_EN.
module agex_br_resolve
    import agex_br_resolve_pkg::*;
#(
    parameter int DBITS        = BR_DBITS,
    parameter int PHT_IDX_BITS = BR_PHT_IDX_BITS,
    parameter int SQUASH_DEPTH = 2,
    parameter int CNT_BITS     = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic                              in_stall,
    input  logic                              in_is_cond,
    input  logic                              in_is_jal,
    input  logic                              in_is_jalr,
    input  logic [2:0]                        in_funct3,
    input  logic [DBITS-1:0]                  in_rs1,
    input  logic [DBITS-1:0]                  in_rs2,
    input  logic [DBITS-1:0]                  in_imm,
    input  logic [DBITS-1:0]                  in_pc,
    input  logic [DBITS-1:0]                  in_pcplus,
    input  logic [DBITS-1:0]                  in_pred_pc,
    input  logic [PHT_IDX_BITS-1:0]           in_pht_index,
    output logic [3+3*DBITS+PHT_IDX_BITS-1:0] from_AGEX_to_FE,
    output logic                              wrong_path,
    output logic [CNT_BITS-1:0]               perf_br,
    output logic [CNT_BITS-1:0]               perf_mispred,
    output logic [CNT_BITS-1:0]               perf_squash,
    output logic                              debug_state
);

    localparam int CW = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);

    // Handshake: in_valid marks an occupied AGEX slot; the slot advances only when
    // in_valid=1 and in_stall=0 (in_stall is the inverted ready). Every resolve,
    // squash decrement and counter update is tied to that advance.
    br_state_t         state;
    logic [CW-1:0]     cnt;
    logic              cmp;
    logic              advance;
    logic              resolve;
    logic              taken;
    logic              mispred;
    logic [DBITS-1:0]  target;
    logic [DBITS-1:0]  actual;

    agex_br_resolve_br_cond_eval #(.DBITS(DBITS)) u_cond (
        .funct3 (in_funct3),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .cmp    (cmp)
    );

    assign wrong_path  = (state == ST_SQUASH);
    assign debug_state = state;
    assign advance     = in_valid & ~in_stall;
    assign resolve     = ~reset & advance & ~wrong_path & (in_is_cond | in_is_jal | in_is_jalr);

    assign target  = in_is_jalr ? ((in_rs1 + in_imm) & ~DBITS'(1)) : (in_pc + in_imm);
    assign taken   = in_is_jal | in_is_jalr | (in_is_cond & cmp);
    assign actual  = taken ? target : in_pcplus;
    assign mispred = resolve & (actual != in_pred_pc);

    // Non-resolving cycles present an all-zero bus so FE never trains on stale data
    assign from_AGEX_to_FE = resolve ? {1'b1, mispred, taken, target, in_pcplus, in_pc, in_pht_index}
                                     : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mispred && (SQUASH_DEPTH != 0)) begin
                        state <= ST_SQUASH;
                        cnt   <= CW'(SQUASH_DEPTH);
                    end
                end
                ST_SQUASH: begin
                    if (advance) begin
                        if (cnt == CW'(1)) begin
                            state <= ST_RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BR_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_br      <= '0;
            perf_mispred <= '0;
            perf_squash  <= '0;
        end else begin
            if (resolve && (perf_br != '1))
                perf_br <= perf_br + CNT_BITS'(1);
            if (mispred && (perf_mispred != '1))
                perf_mispred <= perf_mispred + CNT_BITS'(1);
            if (wrong_path && advance && (perf_squash != '1))
                perf_squash <= perf_squash + CNT_BITS'(1);
        end
    end
`else
    assign perf_br      = '0;
    assign perf_mispred = '0;
    assign perf_squash  = '0;
`endif

endmodule

// File: tb/tb_agex_br_resolve.sv
// Directed bench for agex_br_resolve: hand-computed bus, wrong_path and state expectations.
module tb_agex_br_resolve;
    import agex_br_resolve_pkg::*;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_COND = 2'd1;
    localparam logic [1:0] K_JAL  = 2'd2;
    localparam logic [1:0] K_JALR = 2'd3;

    logic         clk;
    logic         reset;
    logic         in_valid, in_stall, in_is_cond, in_is_jal, in_is_jalr;
    logic [2:0]   in_funct3;
    logic [31:0]  in_rs1, in_rs2, in_imm, in_pc, in_pcplus, in_pred_pc;
    logic [7:0]   in_pht_index;
    logic [106:0] from_AGEX_to_FE;
    logic         wrong_path;
    logic [31:0]  perf_br, perf_mispred, perf_squash;
    logic         debug_state;

    int n_vec = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    agex_br_resolve dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_stall        (in_stall),
        .in_is_cond      (in_is_cond),
        .in_is_jal       (in_is_jal),
        .in_is_jalr      (in_is_jalr),
        .in_funct3       (in_funct3),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_imm          (in_imm),
        .in_pc           (in_pc),
        .in_pcplus       (in_pcplus),
        .in_pred_pc      (in_pred_pc),
        .in_pht_index    (in_pht_index),
        .from_AGEX_to_FE (from_AGEX_to_FE),
        .wrong_path      (wrong_path),
        .perf_br         (perf_br),
        .perf_mispred    (perf_mispred),
        .perf_squash     (perf_squash),
        .debug_state     (debug_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [106:0] bus(input logic mis, input logic tk, input logic [31:0] tgt,
                                         input logic [31:0] pcp, input logic [31:0] pc,
                                         input logic [7:0] pht);
        return {1'b1, mis, tk, tgt, pcp, pc, pht};
    endfunction

    // driver: apply one AGEX slot after the falling edge, settle, return for checks
    task automatic drive(input logic v, input logic s, input logic [1:0] kind, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [31:0] pred, input logic [7:0] pht);
        @(negedge clk);
        in_valid     = v;
        in_stall     = s;
        in_is_cond   = (kind == K_COND);
        in_is_jal    = (kind == K_JAL);
        in_is_jalr   = (kind == K_JALR);
        in_funct3    = f3;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_imm       = imm;
        in_pc        = pc;
        in_pcplus    = pc + 32'd4;
        in_pred_pc   = pred;
        in_pht_index = pht;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, K_NONE, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 8'd0);
    endtask

    task automatic alu(input logic [31:0] pc);
        drive(1'b1, 1'b0, K_NONE, 3'd0, 32'd0, 32'd0, 32'd0, pc, pc + 32'd4, 8'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_stall = 0; in_is_cond = 0; in_is_jal = 0; in_is_jalr = 0;
        in_funct3 = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_pc = 0; in_pcplus = 0;
        in_pred_pc = 0; in_pht_index = 0;

        // reset: bus forced to zero even with a mispredicting branch presented
        drive(1'b1, 1'b0, K_COND, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 32'h104, 8'h11);
        check("rst_bus", from_AGEX_to_FE, 107'd0);
        idle();
        check("rst_wp", wrong_path, 1'b0);
        check("rst_state", debug_state, ST_RUN);
        check("rst_perf_br", perf_br, 32'd0);
        reset = 1'b0;

        // 1: BEQ taken, predicted not-taken -> redirect and 2-instruction squash
        drive(1'b1, 1'b0, K_COND, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 32'h104, 8'h11);
        check("t1_bus", from_AGEX_to_FE, bus(1'b1, 1'b1, 32'h120, 32'h104, 32'h100, 8'h11));
        check("t1_wp0", wrong_path, 1'b0);
        alu(32'h104);
        check("t1_wp1", wrong_path, 1'b1);
        check("t1_state", debug_state, ST_SQUASH);
        check("t1_wpbus", from_AGEX_to_FE, 107'd0);
        alu(32'h108);
        check("t1_wp2", wrong_path, 1'b1);
        idle();
        check("t1_wp_end", wrong_path, 1'b0);
`ifdef BR_PERF_CNT_EN
        check("t1_perf_br", perf_br, 32'd1);
        check("t1_perf_mis", perf_mispred, 32'd1);
        check("t1_perf_sq", perf_squash, 32'd2);
`else
        check("t1_perf_br", perf_br, 32'd0);
        check("t1_perf_mis", perf_mispred, 32'd0);
        check("t1_perf_sq", perf_squash, 32'd0);
`endif

        // 2: BNE not taken, correctly predicted
        drive(1'b1, 1'b0, K_COND, 3'b001, 32'd7, 32'd7, 32'h40, 32'h200, 32'h204, 8'h22);
        check("t2_bus", from_AGEX_to_FE, bus(1'b0, 1'b0, 32'h240, 32'h204, 32'h200, 8'h22));
        idle();
        check("t2_wp", wrong_path, 1'b0);

        // 3: JALR clears bit 0 of the target
        drive(1'b1, 1'b0, K_JALR, 3'b000, 32'h1003, 32'd0, 32'd0, 32'h300, 32'h1002, 8'h33);
        check("t3a_bus", from_AGEX_to_FE, bus(1'b0, 1'b1, 32'h1002, 32'h304, 32'h300, 8'h33));
        drive(1'b1, 1'b0, K_JALR, 3'b000, 32'h1003, 32'd0, 32'd0, 32'h300, 32'h1004, 8'h33);
        check("t3b_bus", from_AGEX_to_FE, bus(1'b1, 1'b1, 32'h1002, 32'h304, 32'h300, 8'h33));
        alu(32'h1004);
        check("t3_wp1", wrong_path, 1'b1);
        alu(32'h1008);
        check("t3_wp2", wrong_path, 1'b1);

        // compare codes and mod-2^32 target wrap, all correctly predicted
        drive(1'b1, 1'b0, K_COND, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'hFFFF_FFF0, 32'h10, 8'h44);
        check("t3_wp_end", wrong_path, 1'b0);
        check("blt_bus", from_AGEX_to_FE, bus(1'b0, 1'b1, 32'h10, 32'hFFFF_FFF4, 32'hFFFF_FFF0, 8'h44));
        drive(1'b1, 1'b0, K_COND, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 8'h44);
        check("bltu_bus", from_AGEX_to_FE, bus(1'b0, 1'b0, 32'h10, 32'hFFFF_FFF4, 32'hFFFF_FFF0, 8'h44));
        drive(1'b1, 1'b0, K_COND, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 8'h44);
        check("bge_bus", from_AGEX_to_FE, bus(1'b0, 1'b0, 32'h10, 32'hFFFF_FFF4, 32'hFFFF_FFF0, 8'h44));
        drive(1'b1, 1'b0, K_COND, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'hFFFF_FFF0, 32'h10, 8'h44);
        check("bgeu_bus", from_AGEX_to_FE, bus(1'b0, 1'b1, 32'h10, 32'hFFFF_FFF4, 32'hFFFF_FFF0, 8'h44));
        drive(1'b1, 1'b0, K_COND, 3'b010, 32'd3, 32'd3, 32'h8, 32'h700, 32'h704, 8'h55);
        check("f3_010_bus", from_AGEX_to_FE, bus(1'b0, 1'b0, 32'h708, 32'h704, 32'h700, 8'h55));
        drive(1'b1, 1'b0, K_JAL, 3'b000, 32'd0, 32'd0, 32'hFFFF_FF00, 32'h500, 32'h400, 8'h66);
        check("jal_bus", from_AGEX_to_FE, bus(1'b0, 1'b1, 32'h400, 32'h504, 32'h500, 8'h66));
        idle();
        check("tbl_wp", wrong_path, 1'b0);

        // 4: stalled mispredicting branch resolves once, in its advance cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, K_COND, 3'b000, 32'd1, 32'd1, 32'h10, 32'h400, 32'h404, 8'h77);
            check("t4_stall_bus", from_AGEX_to_FE, 107'd0);
        end
        drive(1'b1, 1'b0, K_COND, 3'b000, 32'd1, 32'd1, 32'h10, 32'h400, 32'h404, 8'h77);
        check("t4_adv_bus", from_AGEX_to_FE, bus(1'b1, 1'b1, 32'h410, 32'h404, 32'h400, 8'h77));

        // 5: bubble and stall hold the squash; only advances count down
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        idle();
        check("t5_bubble_wp", wrong_path, exp_q.pop_front());
        drive(1'b1, 1'b1, K_COND, 3'b000, 32'd2, 32'd2, 32'h8, 32'h600, 32'h604, 8'h99);
        check("t5_stall_wp", wrong_path, exp_q.pop_front());
        drive(1'b1, 1'b0, K_COND, 3'b000, 32'd2, 32'd2, 32'h8, 32'h600, 32'h604, 8'h99);
        check("t5_adv1_wp", wrong_path, exp_q.pop_front());
        check("t5_adv1_bus", from_AGEX_to_FE, 107'd0);
        alu(32'h604);
        check("t5_adv2_wp", wrong_path, exp_q.pop_front());
        idle();
        check("t5_end_wp", wrong_path, exp_q.pop_front());
        check("t5_end_state", debug_state, ST_RUN);

        // 6: reset in the middle of a squash window
        drive(1'b1, 1'b0, K_JAL, 3'b000, 32'd0, 32'd0, 32'h40, 32'h800, 32'h804, 8'h88);
        check("t6_bus", from_AGEX_to_FE, bus(1'b1, 1'b1, 32'h840, 32'h804, 32'h800, 8'h88));
        alu(32'h804);
        check("t6_wp", wrong_path, 1'b1);
        reset = 1'b1;
        drive(1'b1, 1'b0, K_COND, 3'b000, 32'd0, 32'd0, 32'h10, 32'h900, 32'h904, 8'h12);
        check("t6_rst_wp", wrong_path, 1'b0);
        check("t6_rst_state", debug_state, ST_RUN);
        check("t6_rst_bus", from_AGEX_to_FE, 107'd0);
        check("t6_rst_perf_mis", perf_mispred, 32'd0);
        idle();
        reset = 1'b0;
        idle();
        check("t6_after_wp", wrong_path, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
